// File: rtl/approx_div_ctrl_pkg.sv
// Shared types, constants and the Mitchell antilog helper for the
// approximate divider controller.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      NORM_A,
      NORM_B,
      CALC,
      OUT
   } state_t;

   // Log value is {k[3:0], f[6:0]}: integer part of log2 above a 7-bit fraction.
   localparam int LOG_W  = 11;
   localparam int FRAC_W = 7;

   localparam logic [15:0] QSAT = 16'hFFFF;

   // Antilog of a signed log difference: 1.f scaled by 2^(integer part).
   // The mantissa carries 7 fraction bits, so an integer part of 7 is a
   // left shift of zero. Results beyond 16 bits saturate; very negative
   // exponents flush to zero.
   function automatic logic [15:0] mitchellAntilog(input logic signed [12:0] logDiff);
      logic signed [5:0] intPart;
      logic [31:0]       mant;
      logic [4:0]        shAmt;
      logic [15:0]       res;
      intPart = logDiff[12:7];
      mant    = {24'd0, 1'b1, logDiff[6:0]};
      shAmt   = 5'd0;
      res     = 16'd0;
      if (intPart < -6'sd8) begin
         res = 16'd0;
      end else begin
         if (intPart >= 6'sd7) begin
            shAmt = 5'(intPart - 6'sd7);
            mant  = mant << shAmt;
         end else begin
            shAmt = 5'(6'sd7 - intPart);
            mant  = mant >> shAmt;
         end
         res = (mant > 32'h0000_FFFF) ? QSAT : mant[15:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/approx_div_ctrl_if.sv
// Operand and result handshake bundle between a producer/consumer (master)
// and the divider controller (slave).
interface approx_div_ctrl_if;

   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic        div_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, div_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, div_zero
   );

endinterface

// File: rtl/approx_div_ctrl_lod_norm.sv
// Leading-one detector and normaliser: gives the integer log2 (k) and the
// seven bits directly below the leading one (f). A zero input reports k=0,
// f=0 and raises the zero flag.
module lod_norm (
   input  logic [15:0] i_x,
   output logic [3:0]  o_k,
   output logic [6:0]  o_f,
   output logic        o_zero
);

   // Scan upward so the highest set bit wins, then left-justify under it.
   always_comb begin
      o_k = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (i_x[i]) begin
            o_k = 4'(i);
         end
      end
      o_f    = 7'((i_x << (4'd15 - o_k)) >> 8);
      o_zero = (i_x == 16'd0);
   end

endmodule

// File: rtl/approx_div_ctrl.sv
// Sequencing controller for a Mitchell log-domain approximate divider.
// One operand pair per transaction; a single normaliser is shared between
// the dividend (NORM_A) and the divisor (NORM_B). The quotient is formed in
// CALC and presented in OUT until the consumer accepts it.
module approx_div_ctrl #(
   parameter logic signed [7:0] COMP   = 8'sd0,
   parameter int                FRAC_W = 7
) (
   input logic             clk,
   input logic             rst,
   approx_div_ctrl_if.slave bus
);

   import div_pkg::*;

   state_t r_state;
   state_t w_nextState;

   logic [15:0]       r_a;
   logic [15:0]       r_b;
   logic [3:0]        r_ka;
   logic [3:0]        r_kb;
   logic [FRAC_W-1:0] r_fa;
   logic [FRAC_W-1:0] r_fb;
   logic              r_za;
   logic              r_zb;
   logic [15:0]       r_quot;
   logic              r_dz;

   logic [15:0]       w_normIn;
   logic [3:0]        w_k;
   logic [6:0]        w_f;
   logic              w_zero;

   logic [LOG_W-1:0]  w_logA;
   logic [LOG_W-1:0]  w_logB;
   logic signed [12:0] w_diff;
   logic signed [12:0] w_compExt;
   logic signed [12:0] w_logL;
   logic [15:0]       w_quot;

   // The one normaliser looks at the divisor only while in NORM_B.
   assign w_normIn = (r_state == NORM_B) ? r_b : r_a;

   lod_norm u_lodNorm (
      .i_x    (w_normIn),
      .o_k    (w_k),
      .o_f    (w_f),
      .o_zero (w_zero)
   );

   // Log difference with compensation when the fraction subtraction borrows,
   // then antilog; a zero divisor dominates a zero dividend.
   always_comb begin
      w_logA    = {r_ka, r_fa};
      w_logB    = {r_kb, r_fb};
      w_diff    = $signed({2'b00, w_logA}) - $signed({2'b00, w_logB});
      w_compExt = {{5{COMP[7]}}, COMP};
      w_logL    = (r_fa < r_fb) ? (w_diff + w_compExt) : w_diff;
      if (r_zb) begin
         w_quot = QSAT;
      end else if (r_za) begin
         w_quot = 16'd0;
      end else begin
         w_quot = mitchellAntilog(w_logL);
      end
   end

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake outputs; only IDLE accepts, only OUT presents.
   always_comb begin
      w_nextState   = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               w_nextState = NORM_A;
            end
         end
         NORM_A: w_nextState = NORM_B;
         NORM_B: w_nextState = CALC;
         CALC:   w_nextState = OUT;
         OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Operand capture, per-operand log registers and the result register;
   // each is written in exactly one state so the result holds afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= 16'd0;
         r_b    <= 16'd0;
         r_ka   <= 4'd0;
         r_kb   <= 4'd0;
         r_fa   <= '0;
         r_fb   <= '0;
         r_za   <= 1'b0;
         r_zb   <= 1'b0;
         r_quot <= 16'd0;
         r_dz   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a <= bus.dividend;
                  r_b <= bus.divisor;
               end
            end
            NORM_A: begin
               r_ka <= w_k;
               r_fa <= w_f;
               r_za <= w_zero;
            end
            NORM_B: begin
               r_kb <= w_k;
               r_fb <= w_f;
               r_zb <= w_zero;
            end
            CALC: begin
               r_quot <= w_quot;
               r_dz   <= r_zb;
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient = r_quot;
   assign bus.div_zero = r_dz;

endmodule
